// File: rtl/komut_getir_pkg.sv
// Shared types and constants for the komut_getir instruction fetch stage.
package komut_getir_pkg;

  localparam int ADDR_W  = 32;
  localparam int KOMUT_W = 32;
  localparam logic [ADDR_W-1:0] PC_ADIM = ADDR_W'(4);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [KOMUT_W-1:0] komut;
  } komut_girdi_t;

  function automatic logic hizali(input logic [ADDR_W-1:0] addr);
    return (addr & ADDR_W'(3)) == '0;
  endfunction

endpackage

// File: rtl/komut_getir_fifo.sv
// Prefetch buffer holding {pc, instruction} pairs; flush wins over push and pop.
module komut_fifo
  import komut_getir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  komut_girdi_t             push_data_i,
  input  logic                     pop_i,
  output komut_girdi_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  komut_girdi_t   mem_q [DEPTH];
  logic [AW-1:0]  wrPtr_q, wrPtr_d;
  logic [AW-1:0]  rdPtr_q, rdPtr_d;
  logic [AW:0]    count_q, count_d;
  logic           pushOk, popOk;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign pushOk  = push_i & ~full_o;
  assign popOk   = pop_i & ~empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
      if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
      count_d = count_q + (AW+1)'(pushOk) - (AW+1)'(popOk);
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (pushOk && !flush_i) mem_q[wrPtr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/komut_getir.sv
// Instruction fetch stage: credit-limited sequential reads, prefetch buffer,
// redirect flush with stale-response dropping and sticky misalignment error.
module komut_getir
  import komut_getir_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_istek,
  output logic [ADDR_W-1:0]  mem_adres,
  input  logic               mem_kabul,
  input  logic               mem_yanit_gecerli,
  input  logic [KOMUT_W-1:0] mem_yanit,
  input  logic               yonlendir,
  input  logic [ADDR_W-1:0]  yeni_pc,
  output logic               komut_gecerli,
  output logic [KOMUT_W-1:0] komut,
  output logic [ADDR_W-1:0]  komut_pc,
  input  logic               komut_hazir,
  output logic               hata
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fp_q, fp_d;
  logic [ADDR_W-1:0] rp_q, rp_d;
  logic [CW-1:0]     bekleyen_q, bekleyen_d;
  logic [CW-1:0]     dusur_q, dusur_d;
  logic              hata_q, hata_d;

  logic              istekKabul, yanitDusur, kredi;
  logic              fifoPush, fifoPop, fifoFull, fifoEmpty;
  logic [CW-1:0]     fifoCount;
  komut_girdi_t      fifoHead, fifoGiris;

  // bekleyen counts every read in flight, including ones already marked for dropping.
  assign kredi      = ({1'b0, fifoCount} + {1'b0, bekleyen_q}) < (CW+1)'(DEPTH);
  assign mem_istek  = reset & ~hata_q & ~yonlendir & kredi;
  assign mem_adres  = fp_q;
  assign istekKabul = mem_istek & mem_kabul;
  assign yanitDusur = mem_yanit_gecerli & (dusur_q != '0);
  assign fifoPush   = mem_yanit_gecerli & ~yanitDusur;
  assign fifoPop    = komut_gecerli & komut_hazir;
  assign fifoGiris  = '{pc: rp_q, komut: mem_yanit};

  assign komut_gecerli = ~fifoEmpty;
  assign komut         = fifoHead.komut;
  assign komut_pc      = fifoHead.pc;
  assign hata          = hata_q;

  komut_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (yonlendir),
    .push_i      (fifoPush),
    .push_data_i (fifoGiris),
    .pop_i       (fifoPop),
    .head_o      (fifoHead),
    .count_o     (fifoCount),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty)
  );

  always_comb begin
    fp_d       = fp_q;
    rp_d       = rp_q;
    bekleyen_d = bekleyen_q + CW'(istekKabul) - CW'(mem_yanit_gecerli);
    dusur_d    = dusur_q - CW'(yanitDusur);
    hata_d     = hata_q;
    if (yonlendir) begin
      // Whatever is still in flight after this edge belongs to the old stream.
      fp_d    = yeni_pc;
      rp_d    = yeni_pc;
      dusur_d = bekleyen_q - CW'(mem_yanit_gecerli);
      if (!hizali(yeni_pc)) hata_d = 1'b1;
    end else begin
      if (istekKabul) fp_d = fp_q + PC_ADIM;
      if (fifoPush)   rp_d = rp_q + PC_ADIM;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fp_q       <= RESET_PC;
      rp_q       <= RESET_PC;
      bekleyen_q <= '0;
      dusur_q    <= '0;
      hata_q     <= 1'b0;
    end else begin
      fp_q       <= fp_d;
      rp_q       <= rp_d;
      bekleyen_q <= bekleyen_d;
      dusur_q    <= dusur_d;
      hata_q     <= hata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && fifoPush && !yonlendir) assert (!fifoFull);
  end

endmodule

// File: tb/tb_komut_getir.sv
// Bench for komut_getir: in-order memory model, stream-level reference model,
// directed scenarios followed by a randomized phase.
module tb_komut_getir;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_istek, mem_kabul, mem_yanit_gecerli;
  logic [31:0] mem_adres, mem_yanit;
  logic        yonlendir, komut_gecerli, komut_hazir, hata;
  logic [31:0] yeni_pc, komut, komut_pc;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int teslim = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } istek_t;
  istek_t pend[$];

  logic [31:0] expPc, expFetch, prevAdr;
  logic        hataM, prevBekle;

  komut_getir #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_istek         (mem_istek),
    .mem_adres         (mem_adres),
    .mem_kabul         (mem_kabul),
    .mem_yanit_gecerli (mem_yanit_gecerli),
    .mem_yanit         (mem_yanit),
    .yonlendir         (yonlendir),
    .yeni_pc           (yeni_pc),
    .komut_gecerli     (komut_gecerli),
    .komut             (komut),
    .komut_pc          (komut_pc),
    .komut_hazir       (komut_hazir),
    .hata              (hata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitGecerli(input string tag);
    for (int i = 0; i < 30 && !komut_gecerli; i++) step();
    chk(tag, komut_gecerli, 1);
  endtask

  // Memory: accepts at the edge, answers in order no earlier than lat cycles later.
  initial begin
    mem_yanit_gecerli = 1'b0;
    mem_yanit = '0;
    forever begin
      @(negedge clk);
      if (!reset) pend.delete();
      else begin
        if (mem_istek && mem_kabul) begin
          pend.push_back('{addr: mem_adres, due: cyc + lat});
          chk("inflight", 32'(pend.size() <= DEPTH), 1);
        end
        if (mem_yanit_gecerli) void'(pend.pop_front());
      end
      @(posedge clk);
      cyc++;
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_yanit_gecerli = 1'b1;
        mem_yanit = img(pend[0].addr);
      end else begin
        mem_yanit_gecerli = 1'b0;
        mem_yanit = $urandom;
      end
    end
  end

  // Stream model: the core must see consecutive PCs from the last redirect target.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        expPc = RESET_PC; expFetch = RESET_PC; hataM = 1'b0; prevBekle = 1'b0;
      end else begin
        chk("hata", hata, hataM);
        if (hataM) begin
          chk("hataIstek", mem_istek, 0);
          chk("hataGecerli", komut_gecerli, 0);
        end
        if (yonlendir) chk("yonIstek", mem_istek, 0);
        if (prevBekle && !yonlendir && !hataM) begin
          chk("tutIstek", mem_istek, 1);
          chk("tutAdres", mem_adres, prevAdr);
        end
        if (mem_istek) chk("adres", mem_adres, expFetch);
        if (komut_gecerli && komut_hazir && !yonlendir) begin
          chk("komutPc", komut_pc, expPc);
          chk("komut", komut, img(expPc));
          expPc += 4;
          teslim++;
        end
        prevBekle = mem_istek && !mem_kabul;
        prevAdr = mem_adres;
        if (yonlendir) begin
          expPc = yeni_pc; expFetch = yeni_pc;
          if (yeni_pc[1:0] != 2'b00) hataM = 1'b1;
        end else if (mem_istek && mem_kabul) expFetch += 4;
      end
    end
  end

  initial begin
    reset = 1'b0; mem_kabul = 1'b1; yonlendir = 1'b0; yeni_pc = '0; komut_hazir = 1'b1;
    repeat (3) step();
    chk("rstIstek", mem_istek, 0);
    chk("rstAdres", mem_adres, RESET_PC);
    chk("rstGecerli", komut_gecerli, 0);
    chk("rstKomut", komut, 0);
    chk("rstPc", komut_pc, 0);
    chk("rstHata", hata, 0);

    // Fill from reset with a latency-1 memory.
    reset = 1'b1; #1;
    chk("t1Istek", mem_istek, 1);
    chk("t1Adres", mem_adres, 32'h0);
    chk("t1Bos0", komut_gecerli, 0);
    step(); chk("t1Bos1", komut_gecerli, 0);
    step(); chk("t1Ilk", komut_gecerli, 1); chk("t1Pc0", komut_pc, 32'h0); chk("t1Komut0", komut, img(32'h0));
    step(); chk("t1Pc4", komut_pc, 32'h4);
    step(); chk("t1Pc8", komut_pc, 32'h8);
    repeat (4) step();

    // Core stall fills the buffer and stops issue.
    komut_hazir = 1'b0;
    repeat (10) step();
    chk("t2Istek", mem_istek, 0);
    chk("t2Gecerli", komut_gecerli, 1);
    chk("t2Bas", komut_pc, expPc);
    komut_hazir = 1'b1;
    repeat (8) step();

    // Redirect with two slow reads in flight.
    lat = 3; mem_kabul = 1'b0;
    repeat (6) step();
    mem_kabul = 1'b1;
    step(); step();
    mem_kabul = 1'b0; yonlendir = 1'b1; yeni_pc = 32'h40; #1;
    chk("t3Bekleyen", 32'(pend.size()), 2);
    chk("t3Istek", mem_istek, 0);
    step(); yonlendir = 1'b0; mem_kabul = 1'b1;
    waitGecerli("t3Gecerli");
    chk("t3Pc", komut_pc, 32'h40);
    repeat (10) step();

    // Misaligned redirect is sticky until reset.
    yonlendir = 1'b1; yeni_pc = 32'h42;
    step(); yonlendir = 1'b0;
    chk("t4Hata", hata, 1);
    repeat (4) begin
      step();
      chk("t4Hata", hata, 1); chk("t4Istek", mem_istek, 0); chk("t4Gecerli", komut_gecerli, 0);
    end
    lat = 1; reset = 1'b0;
    step(); step();
    reset = 1'b1; #1;
    chk("t4HataTemiz", hata, 0);
    chk("t4Istek", mem_istek, 1);
    chk("t4Adres", mem_adres, RESET_PC);

    // Held request, then withdrawn by a redirect.
    step(); step();
    mem_kabul = 1'b0; #1;
    chk("t5Istek", mem_istek, 1); chk("t5Adres", mem_adres, 32'h8);
    repeat (2) begin
      step(); chk("t5Istek", mem_istek, 1); chk("t5Adres", mem_adres, 32'h8);
    end
    step(); yonlendir = 1'b1; yeni_pc = 32'h100; #1;
    chk("t5Geri", mem_istek, 0);
    step(); yonlendir = 1'b0; #1;
    chk("t5Istek", mem_istek, 1); chk("t5Adres", mem_adres, 32'h100);
    mem_kabul = 1'b1;
    step(); chk("t5Sonraki", mem_adres, 32'h104);
    waitGecerli("t5Gecerli");
    chk("t5Pc", komut_pc, 32'h100);

    // Reset while three entries are buffered.
    mem_kabul = 1'b0; repeat (4) step();
    komut_hazir = 1'b0; mem_kabul = 1'b1;
    repeat (3) step();
    mem_kabul = 1'b0;
    repeat (3) step();
    chk("t6Dolu", komut_gecerli, 1);
    reset = 1'b0;
    step();
    chk("t6Bos", komut_gecerli, 0);
    chk("t6Istek", mem_istek, 0);
    reset = 1'b1; komut_hazir = 1'b1; mem_kabul = 1'b1; #1;
    chk("t6Adres", mem_adres, RESET_PC);
    waitGecerli("t6Gecerli");
    chk("t6Pc", komut_pc, RESET_PC);

    // Random traffic with aligned redirects, some near the top of the address space.
    for (int i = 0; i < 3000; i++) begin
      komut_hazir = ($urandom_range(0, 9) < 7);
      mem_kabul = ($urandom_range(0, 9) < 7);
      if (i % 500 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 49) == 0) begin
        yonlendir = 1'b1;
        yeni_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 + 32'($urandom_range(0, 7)) * 4)
                                              : 32'($urandom_range(0, 255)) * 4;
      end else yonlendir = 1'b0;
      step();
    end
    yonlendir = 1'b0; komut_hazir = 1'b1; mem_kabul = 1'b1;
    repeat (10) step();
    chk("teslimVar", 32'(teslim > 500), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
